// File: rtl/sha256_digest_collector.sv
// Collects the eight 32-bit SHA-256 digest words into a 256-bit register.
// It then streams the digest out over valid/ready, as raw bytes or as lowercase ASCII hex.
module sha256_digest_collector #(
   parameter bit HEX_MODE  = 1'b0,
   parameter int NUM_WORDS = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  i_word_in,
   input  logic         i_word_valid,
   input  logic         i_cmp_en,
   input  logic [255:0] i_expected_digest,
   output logic [255:0] o_digest,
   output logic         o_digest_valid,
   output logic         o_match,
   output logic [7:0]   o_byte_out,
   output logic         o_byte_valid,
   input  logic         i_byte_ready,
   output logic         o_busy,
   output logic         o_frame_err,
   output logic         o_overrun,
   output logic [1:0]   o_dbg_state
);

   // Byte stream: o_byte_valid is high for the whole of EMIT.
   // A byte transfers on any cycle with o_byte_valid && i_byte_ready.
   // o_byte_out holds its value until that transfer happens.
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CAPTURE = 2'd1, ST_EMIT = 2'd2} state_t;

   localparam logic [3:0] WORDS     = 4'(NUM_WORDS);
   localparam logic [5:0] LAST_BYTE = HEX_MODE ? 6'd63 : 6'd31;

   state_t       r_state, w_state_nxt;
   logic         r_armed;
   logic [3:0]   r_word_cnt;
   logic [5:0]   r_byte_cnt;
   logic [255:0] r_digest;
   logic         r_digest_valid, r_match, r_frame_err, r_overrun;

   logic         w_frame_start, w_cap_word, w_short, w_full, w_handshake, w_last;
   logic [3:0]   w_nib [64];
   logic [3:0]   w_hex_nib;
   logic [7:0]   w_raw_byte, w_hex_char, w_char;

   // armed drops on the first high word_valid cycle, so a held hash_valid cannot restart a frame.
   assign w_frame_start = i_word_valid && r_armed;
   assign w_cap_word    = (r_state == ST_CAPTURE) && i_word_valid && (r_word_cnt != WORDS);
   assign w_short       = (r_state == ST_CAPTURE) && !i_word_valid && (r_word_cnt != WORDS);
   assign w_full        = (r_state == ST_CAPTURE) && (r_word_cnt == WORDS);
   assign w_handshake   = (r_state == ST_EMIT) && i_byte_ready;
   assign w_last        = w_handshake && (r_byte_cnt == LAST_BYTE);

   always_comb begin
      for (int k = 0; k < 64; k++) w_nib[k] = r_digest[255-4*k -: 4];
   end

   assign w_raw_byte = {w_nib[{r_byte_cnt[4:0], 1'b0}], w_nib[{r_byte_cnt[4:0], 1'b1}]};
   assign w_hex_nib  = w_nib[r_byte_cnt];
   assign w_hex_char = (w_hex_nib < 4'd10) ? 8'h30 + {4'h0, w_hex_nib} : 8'h57 + {4'h0, w_hex_nib};
   assign w_char     = HEX_MODE ? w_hex_char : w_raw_byte;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_frame_start) w_state_nxt = ST_CAPTURE;
         ST_CAPTURE: if (w_full) w_state_nxt = ST_EMIT;
                     else if (w_short) w_state_nxt = ST_IDLE;
         ST_EMIT:    if (w_last) w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_busy       = 1'b0;
      o_byte_valid = 1'b0;
      o_byte_out   = 8'h00;
      case (r_state)
         ST_CAPTURE: o_busy = 1'b1;
         ST_EMIT: begin
            o_busy       = 1'b1;
            o_byte_valid = 1'b1;
            o_byte_out   = w_char;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed        <= 1'b1;
         r_word_cnt     <= 4'd0;
         r_byte_cnt     <= 6'd0;
         r_digest       <= '0;
         r_digest_valid <= 1'b0;
         r_match        <= 1'b0;
         r_frame_err    <= 1'b0;
         r_overrun      <= 1'b0;
      end else begin
         r_armed     <= !i_word_valid ? 1'b1 : (w_frame_start ? 1'b0 : r_armed);
         r_frame_err <= w_short;
         r_overrun   <= w_frame_start && (r_state == ST_EMIT);
         if ((r_state == ST_IDLE) && w_frame_start) begin
            r_digest[255 -: 32] <= i_word_in;
            r_word_cnt          <= 4'd1;
            r_digest_valid      <= 1'b0;
            r_match             <= 1'b0;
         end else if (w_cap_word) begin
            for (int k = 1; k < 8; k++)
               if (r_word_cnt == 4'(k)) r_digest[255-32*k -: 32] <= i_word_in;
            r_word_cnt <= r_word_cnt + 4'd1;
         end else if (w_full) begin
            r_digest_valid <= 1'b1;
            r_match        <= i_cmp_en && (r_digest == i_expected_digest);
            r_word_cnt     <= 4'd0;
         end else if (w_short) begin
            r_digest   <= '0;
            r_word_cnt <= 4'd0;
         end
         if (w_handshake) r_byte_cnt <= w_last ? 6'd0 : r_byte_cnt + 6'd1;
      end
   end

   assign o_digest       = r_digest;
   assign o_digest_valid = r_digest_valid;
   assign o_match        = r_match;
   assign o_frame_err    = r_frame_err;
   assign o_overrun      = r_overrun;
   assign o_dbg_state    = r_state;

endmodule

// File: doc/sha256_digest_collector.md
Name: sha256_digest_collector

Overview:
Downstream consumer of the SHA-256 core's 32-bit digest stream. It captures the eight words presented on consecutive cycles while the core's hash_valid is high, and assembles them into a registered 256-bit digest. It can optionally compare the digest against an expected value. It then emits the digest as a byte stream with a valid/ready handshake, either raw or as ASCII hex, toward a UART or host interface.

Parameters:
HEX_MODE, 0, 0 = 32 raw bytes out; 1 = 64 lowercase ASCII hex chars out, high nibble first.
NUM_WORDS, 8, digest words per frame; fixed at 8 for SHA-256, word 0 is the most significant.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
word_in  in  32  digest word from the core (hash_out)
word_valid  in  1  core hash_valid; a new word every cycle while high; may stay high past word 7
cmp_en  in  1  enable digest comparison; sampled at frame completion
expected_digest  in  256  reference digest; bits 255:224 = word 0
digest  out  256  assembled digest; bits 255:224 = first word captured
digest_valid  out  1  digest and match are valid
match  out  1  digest == expected_digest, only when cmp_en was high
byte_out  out  8  output byte/char
byte_valid  out  1  byte_out valid
byte_ready  in  1  sink accepts byte_out
busy  out  1  high in CAPTURE or EMIT
frame_err  out  1  one-cycle pulse: word_valid dropped before 8 words were captured
overrun  out  1  one-cycle pulse: new frame started while in EMIT; that frame is dropped

Behaviour:
- Reset: every output is 0. State = IDLE, word_cnt = 0, byte_cnt = 0, armed = 1.
- armed flag:
  - Set whenever word_valid is sampled low.
  - Cleared when a frame starts.
  - A frame starts only when word_valid is high and armed is 1. This absorbs the core holding hash_valid with word 7 repeated.
- IDLE:
  - On a frame start, store word_in into word slot 0, set word_cnt = 1, clear digest_valid and match, and go to CAPTURE.
- CAPTURE:
  - Each cycle word_valid is high, store word_in at slot word_cnt and increment.
  - When slot 7 is written: the next cycle raises digest_valid, match <= cmp_en && (digest == expected_digest), and the state goes to EMIT.
  - Latency: digest_valid rises 1 cycle after the 8th word is sampled.
  - If word_valid is low in CAPTURE before slot 7: pulse frame_err, discard the partial digest (digest_valid stays 0), go to IDLE.
- EMIT:
  - byte_valid = 1. byte_out holds steady until a handshake (byte_valid && byte_ready), then byte_cnt increments.
  - HEX_MODE = 0: byte k = digest[255-8k -: 8], k = 0..31.
  - HEX_MODE = 1: char k encodes nibble digest[255-4k -: 4], k = 0..63. Nibble 0-9 maps to 0x30-0x39; nibble a-f maps to 0x61-0x66.
  - On the handshake of the last byte (k = 31 or 63), byte_valid drops the next cycle, byte_cnt = 0, and the state goes to IDLE.
  - digest_valid and match stay high until the next frame starts.
- Frame start while in EMIT: pulse overrun, ignore the words (the producer cannot be stalled), and keep emitting the current digest. armed still clears and re-arms normally.
- Frame start in the same cycle as the final EMIT handshake: treated as overrun. Acceptance happens only in IDLE.
- byte_ready high outside EMIT has no effect. byte_valid never toggles without a handshake.
- Reset mid-operation: immediate return to reset values; the partial digest is lost.

Test Plan:
- SHA-256("abc") words ba7816bf, 8f01cfea, 414140de, 5dae2223, b00361a3, 96177a9c, b410ff61, f20015ad on 8 consecutive cycles, byte_ready=1, HEX_MODE=0 -> digest_valid 1 cycle after word 8; digest = ba7816bf...f20015ad; bytes ba,78,16,bf,...,ad in 32 consecutive cycles.
- Same frame, HEX_MODE=1, cmp_en=1, expected_digest = same value -> match=1; 64 chars "ba7816bf...f20015ad" (0x62,0x61,0x37,0x38,...).
- Same frame, cmp_en=1, expected_digest bit 0 flipped -> match=0, digest_valid=1; cmp_en=0 -> match=0.
- word_valid held 3 extra cycles after word 7 (word 7 repeated) -> no second frame, no overrun; the next frame starts only after word_valid has been low at least 1 cycle.
- word_valid low after 5 words -> frame_err pulses once, digest_valid=0, back to IDLE, byte_valid=0.
- byte_ready toggled 1/0 during EMIT, new frame arriving mid-EMIT -> byte_out stable while stalled, all 32 bytes of the first digest delivered in order, overrun pulses once, the second frame is dropped.
